leiwand_rv32_arb_mem: RTL and testbench

Parametrised multi-port word memory for the leiwand_rv32 SoC. Successor to the single-port simple_mem. It serves NUM_PORTS valid/ready requesters, for example the core instruction and data sides plus a DMA or debug master. Access is round-robin arbitrated, with configurable wait states, byte-lane writes, a base-address window and an out-of-range error flag. It sits between the core bus ports and on-chip RAM/ROM; testbenches preload the contents through the internal array `mem`.

---
 rtl/leiwand_rv32_arb_mem.sv | 166 ++++++++++++++++
 tb/tb_leiwand_rv32_arb_mem.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_arb_mem.sv
// leiwand_rv32_arb_mem: multi-port 32-bit word memory with round-robin arbitration,
// optional wait states, byte-lane writes, base-address window and range error flag.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction; scan valid from last_grant+1 and latch a request
// WAIT   | wait-state down-counter running, access at terminal count 1
// ACCESS | memory read (old word) and byte-lane write, range check
// RESP   | ready/err pulse for the granted port, then back to IDLE
module leiwand_rv32_arb_mem #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned WORDS       = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    valid,
    output logic [NUM_PORTS-1:0]    ready,
    input  logic [32*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0] wdata,
    input  logic [4*NUM_PORTS-1:0]  wen,
    output logic [32*NUM_PORTS-1:0] rdata,
    output logic [NUM_PORTS-1:0]    err
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t                state;
    logic [31:0]           mem [WORDS];
    logic [PW-1:0]         last_grant;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         scan_grant;
    logic [PW-1:0]         cand;
    logic                  scan_hit;
    logic [CW-1:0]         wait_cnt;
    logic [31:0]           sel_addr;
    logic [31:0]           sel_wdata;
    logic [3:0]            sel_wen;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_wen;
    logic [31:0]           rdata_q;
    logic [NUM_PORTS-1:0]  ready_q;
    logic [NUM_PORTS-1:0]  err_q;
    logic [29:0]           word_ofs;
    logic                  in_range;
    logic [IW-1:0]         word_idx;
    logic                  unused_addr_bits;

    // Byte offset within the word plays no part in addressing.
    assign unused_addr_bits = ^lat_addr[1:0];

    // Base is word aligned, so the window check works on word addresses only.
    assign word_ofs = lat_addr[31:2] - BASE_ADDR[31:2];
    assign in_range = (lat_addr[31:2] >= BASE_ADDR[31:2]) && ({2'b00, word_ofs} < 32'(WORDS));
    assign word_idx = word_ofs[IW-1:0];

    // Round-robin scan: first valid port after last_grant, wrapping around.
    always_comb begin
        scan_hit   = 1'b0;
        scan_grant = last_grant;
        cand       = last_grant;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (cand == LAST_PORT) ? '0 : cand + PW'(1);
            if (!scan_hit && valid[cand]) begin
                scan_hit   = 1'b1;
                scan_grant = cand;
            end
        end
    end

    // Select the request fields of the port that wins the scan.
    always_comb begin
        sel_addr  = addr[31:0];
        sel_wdata = wdata[31:0];
        sel_wen   = wen[3:0];
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PW'(p) == scan_grant) begin
                sel_addr  = addr[32*p +: 32];
                sel_wdata = wdata[32*p +: 32];
                sel_wen   = wen[4*p +: 4];
            end
        end
    end

    // Transaction sequencer with registered ready/err/rdata.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ready_q    <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
            last_grant <= LAST_PORT;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= '0;
                    err_q   <= '0;
                    if (scan_hit) begin
                        grant      <= scan_grant;
                        last_grant <= scan_grant;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        lat_wen    <= sel_wen;
                        if (WAIT_STATES > 0) begin
                            wait_cnt <= CW'(WAIT_STATES);
                            state    <= WAIT;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    if (wait_cnt == CW'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (in_range) begin
                        rdata_q <= mem[word_idx];
                        err_q   <= '0;
                    end else begin
                        rdata_q      <= '0;
                        err_q        <= '0;
                        err_q[grant] <= 1'b1;
                    end
                    ready_q        <= '0;
                    ready_q[grant] <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    ready_q <= '0;
                    err_q   <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane write in ACCESS; the read above sees the old word via NBA ordering.
    always_ff @(posedge clk) begin
        if (reset && (state == ACCESS) && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_wen[b]) begin
                    mem[word_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = {NUM_PORTS{rdata_q}};

endmodule

// File: tb/tb_leiwand_rv32_arb_mem.sv
// Bench for leiwand_rv32_arb_mem: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle against a
// transaction-level model (edges since grant, a reference word array).
module tb_leiwand_rv32_arb_mem;

    localparam int          NP    = 3;
    localparam int          WORDS = 32;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     valid;
    logic [NP-1:0]     ready;
    logic [32*NP-1:0]  addr;
    logic [32*NP-1:0]  wdata;
    logic [4*NP-1:0]   wen;
    logic [32*NP-1:0]  rdata;
    logic [NP-1:0]     err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    leiwand_rv32_arb_mem #(
        .NUM_PORTS  (NP),
        .WORDS      (WORDS),
        .WAIT_STATES(WS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .valid(valid),
        .ready(ready),
        .addr (addr),
        .wdata(wdata),
        .wen  (wen),
        .rdata(rdata),
        .err  (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [WORDS];
    bit          m_busy;
    int          m_t;
    int          m_g;
    int          m_last;
    bit          m_found;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wen;
    logic [31:0] m_wofs;
    logic [NP-1:0] exp_ready = '0;
    logic [NP-1:0] exp_err   = '0;
    logic [31:0]   exp_rdata = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy    = 1'b0;
            m_last    = NP - 1;
            exp_ready = '0;
            exp_err   = '0;
            exp_rdata = '0;
        end else if (!m_busy) begin
            if (valid != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NP; k++) begin
                    if (!m_found && valid[2'((m_last + k) % NP)]) begin
                        m_found = 1'b1;
                        m_g     = (m_last + k) % NP;
                    end
                end
                m_last  = m_g;
                m_addr  = addr[32*m_g +: 32];
                m_wdata = wdata[32*m_g +: 32];
                m_wen   = wen[4*m_g +: 4];
                m_busy  = 1'b1;
                m_t     = 0;
            end
        end else begin
            m_t++;
            if (m_t == WS + 1) begin
                m_wofs = (m_addr - BASE) >> 2;
                if (m_addr >= BASE && m_wofs < WORDS) begin
                    exp_rdata = ref_mem[m_wofs[4:0]];
                    for (int b = 0; b < 4; b++)
                        if (m_wen[b]) ref_mem[m_wofs[4:0]][8*b +: 8] = m_wdata[8*b +: 8];
                    exp_err = '0;
                end else begin
                    exp_rdata = '0;
                    exp_err   = NP'(1 << m_g);
                end
                exp_ready = NP'(1 << m_g);
            end else if (m_t == WS + 2) begin
                exp_ready = '0;
                exp_err   = '0;
                m_busy    = 1'b0;
            end
        end
    end

    // ---------------- literal expectations queue ----------------
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } lit_t;
    lit_t lit_q[$];
    lit_t cur;

    function automatic void lit(input string n, input logic [31:0] a, input logic [31:0] r);
        lit_t l;
        l.name = n;
        l.act  = a;
        l.req  = r;
        lit_q.push_back(l);
    endfunction

    // ---------------- single compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (ready !== exp_ready) begin
                failures++;
                $display("FAIL ready actual=%b required=%b at %0t", ready, exp_ready, $time);
            end
            checks++;
            if (err !== exp_err) begin
                failures++;
                $display("FAIL err actual=%b required=%b at %0t", err, exp_err, $time);
            end
            checks++;
            if (rdata !== {NP{exp_rdata}}) begin
                failures++;
                $display("FAIL rdata actual=%h required=%h at %0t", rdata, {NP{exp_rdata}}, $time);
            end
        end
        while (lit_q.size() > 0) begin
            cur = lit_q.pop_front();
            checks++;
            if (cur.act !== cur.req) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", cur.name, cur.act, cur.req);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        valid[2'(p)]       = 1'b1;
        addr[32*p +: 32]   = a;
        wdata[32*p +: 32]  = d;
        wen[4*p +: 4]      = w;
    endtask

    task automatic wait_ready(input int p, input int start, output int n,
                              output logic [31:0] rd, output logic e);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[2'(p)] && n < 30);
        if (!ready[2'(p)]) lit("ready_timeout", 32'd0, 32'd1);
        rd = rdata[32*p +: 32];
        e  = err[2'(p)];
    endtask

    // Issue one request from port p, wait for its ready, release, idle one cycle.
    task automatic xact(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        output int n, output logic [31:0] rd, output logic e);
        drive(p, a, d, w);
        wait_ready(p, 0, n, rd, e);
        valid[2'(p)] = 1'b0;
        @(negedge clk);
    endtask

    function automatic int onehot_port(input logic [NP-1:0] r);
        case (r)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        logic [31:0] rd;
        logic        e;
        logic [31:0] v;
        int          seq [4];
        int          cyc [4];
        int          cnt;
        int          pulses;
        logic [NP-1:0] active;
        int          idx;
        logic [31:0] a;

        reset = 1'b0;
        valid = '0;
        addr  = '0;
        wdata = '0;
        wen   = '0;
        for (int i = 0; i < WORDS; i++) begin
            v          = $urandom;
            dut.mem[i] = v;
            ref_mem[i] = v;
        end
        dut.mem[0]  = 32'h0BAD_C0DE; ref_mem[0]  = 32'h0BAD_C0DE;
        dut.mem[3]  = 32'hDEAD_BEEF; ref_mem[3]  = 32'hDEAD_BEEF;
        dut.mem[5]  = 32'h1122_3344; ref_mem[5]  = 32'h1122_3344;
        dut.mem[6]  = 32'h6666_6666; ref_mem[6]  = 32'h6666_6666;
        dut.mem[31] = 32'h1357_2468; ref_mem[31] = 32'h1357_2468;

        @(negedge clk);
        chk_en = 1'b1;
        lit("reset_ready", 32'(ready), 32'd0);
        lit("reset_err", 32'(err), 32'd0);
        lit("reset_rdata", rdata[31:0], 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // single read, latency 2+WS
        drive(0, 32'h0000_010C, 32'd0, 4'h0);
        wait_ready(0, 0, n, rd, e);
        lit("t1_latency", 32'(n), 32'd4);
        lit("t1_rdata", rd, 32'hDEAD_BEEF);
        lit("t1_err", 32'(e), 32'd0);
        lit("t1_ready_vec", 32'(ready), 32'd1);
        valid[0] = 1'b0;
        @(negedge clk);

        // byte-lane write returns old word, then read shows merged word
        xact(1, 32'h0000_0114, 32'hAABB_CCDD, 4'b0101, n, rd, e);
        lit("t2_write_old", rd, 32'h1122_3344);
        xact(1, 32'h0000_0114, 32'd0, 4'h0, n, rd, e);
        lit("t2_merged", rd, 32'h11BB_33DD);

        // contention: ports 0 and 1 held valid
        drive(0, 32'h0000_0100, 32'd0, 4'h0);
        drive(1, 32'h0000_0104, 32'd0, 4'h0);
        cnt = 0;
        for (int c = 1; c <= 40 && cnt < 4; c++) begin
            @(negedge clk);
            if (ready != '0) begin
                seq[cnt] = onehot_port(ready);
                cyc[cnt] = c;
                cnt++;
            end
        end
        valid = '0;
        @(negedge clk);
        lit("t3_pulses", 32'(cnt), 32'd4);
        if (cnt == 4) begin
            lit("t3_grant0", 32'(seq[0]), 32'd0);
            lit("t3_grant1", 32'(seq[1]), 32'd1);
            lit("t3_grant2", 32'(seq[2]), 32'd0);
            lit("t3_grant3", 32'(seq[3]), 32'd1);
            lit("t3_first_at", 32'(cyc[0]), 32'd4);
            for (int i = 1; i < 4; i++) lit("t3_spacing", 32'(cyc[i] - cyc[i-1]), 32'd5);
        end

        // valid dropped during WAIT still completes
        drive(2, 32'h0000_010C, 32'd0, 4'h0);
        @(negedge clk);
        valid[2] = 1'b0;
        wait_ready(2, 1, n, rd, e);
        lit("t4_latency", 32'(n), 32'd4);
        lit("t4_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clk);

        // out of range below and above the window
        xact(0, 32'h0000_00FC, 32'd0, 4'h0, n, rd, e);
        lit("t5_below_err", 32'(e), 32'd1);
        lit("t5_below_rdata", rd, 32'd0);
        xact(0, 32'h0000_0180, 32'd0, 4'h0, n, rd, e);
        lit("t5_above_err", 32'(e), 32'd1);
        lit("t5_above_rdata", rd, 32'd0);
        xact(0, 32'h0000_0180, 32'hCAFE_F00D, 4'hF, n, rd, e);
        lit("t5_wr_err", 32'(e), 32'd1);
        xact(0, 32'h0000_0100, 32'd0, 4'h0, n, rd, e);
        lit("t5_word0_kept", rd, 32'h0BAD_C0DE);
        xact(0, 32'h0000_017C, 32'd0, 4'h0, n, rd, e);
        lit("t5_word31_kept", rd, 32'h1357_2468);

        // reset during WAIT aborts the write and the ready
        drive(0, 32'h0000_0118, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        reset = 1'b0;
        valid = '0;
        wen   = '0;
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready != '0) pulses++;
        end
        lit("t6_no_ready", 32'(pulses), 32'd0);
        drive(0, 32'h0000_0118, 32'd0, 4'h0);
        drive(1, 32'h0000_0100, 32'd0, 4'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready == '0 && n < 30);
        lit("t6_first_port", 32'(onehot_port(ready)), 32'd0);
        lit("t6_word_kept", rdata[31:0], 32'h6666_6666);
        valid = '0;
        repeat (6) @(negedge clk);

        // randomized traffic
        active = '0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (active[p] && (ready[p] || $urandom_range(0, 63) == 0)) begin
                    active[p] = 1'b0;
                    valid[p]  = 1'b0;
                end
                if (!active[p] && $urandom_range(0, 3) == 0) begin
                    idx = int'($urandom_range(0, 35));
                    a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 15) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
                    drive(p, a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
                    active[p] = 1'b1;
                end
            end
        end
        valid = '0;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
